// File: rtl/fp_accumulate_mc_pkg.sv
// Shared constants and channel state encoding for the multi-channel FP32 accumulator.
package fp_accumulate_mc_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_INF  = 32'h7F80_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,
        CH_ACTIVE  = 2'd1,
        CH_PENDING = 2'd2
    } ch_state_e;

    function automatic logic fp_exp_all_ones(input logic [31:0] x);
        return x[MAN_W +: EXP_W] == {EXP_W{1'b1}};
    endfunction

endpackage

// File: rtl/fp_accumulate_mc_if.sv
// Sample/handshake/result bundle between the multiplier side and the accumulator.
interface fp_accumulate_mc_if #(
    parameter int N_CHAN = 4,
    parameter int CH_W   = 2,
    parameter int CNT_W  = 16
);
    logic [N_CHAN-1:0] start;
    logic [N_CHAN-1:0] finished;
    logic              valid;
    logic [CH_W-1:0]   chan;
    logic [31:0]       data;
    logic [31:0]       result;
    logic [CH_W-1:0]   result_chan;
    logic [CNT_W-1:0]  result_cnt;
    logic              result_ovf;
    logic              done;
    logic [N_CHAN-1:0] busy;
    logic              err;

    modport slave (
        input  start, finished, valid, chan, data,
        output result, result_chan, result_cnt, result_ovf, done, busy, err
    );

    modport master (
        output start, finished, valid, chan, data,
        input  result, result_chan, result_cnt, result_ovf, done, busy, err
    );
endinterface

// File: rtl/fp_accumulate_mc_fp32_add.sv
// Combinational FP32 adder: round-to-nearest-even, denormals flushed to signed zero.
module fp_accumulate_mc_fp32_add
    import fp_accumulate_mc_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);

    logic        w_sa, w_sb, w_a_big, w_sbig;
    logic [7:0]  w_ea, w_eb, w_ebig, w_ediff;
    logic [22:0] w_fa, w_fb;
    logic [26:0] w_mbig, w_msml, w_mal, w_mdif, w_mnorm;
    logic [27:0] w_madd;
    logic [4:0]  w_lz;
    logic signed [9:0] w_enorm;

    assign {w_sa, w_ea, w_fa} = i_a;
    assign {w_sb, w_eb, w_fb} = i_b;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // m carries the hidden bit at [26] and guard/round/sticky at [2:0]
    function automatic logic [31:0] round_pack(input logic s, input logic signed [9:0] e,
                                               input logic [26:0] m);
        logic [24:0]       mr;
        logic              up;
        logic signed [9:0] er;
        if (e <= 0) return {s, 31'b0};
        up = m[2] & (m[1] | m[0] | m[3]);
        mr = {1'b0, m[26:3]} + 25'(up);
        er = e;
        if (mr[24]) begin
            mr = mr >> 1;
            er = e + 10'sd1;
        end
        if (er >= 10'sd255) return {s, FP_INF[30:0]};
        return {s, er[7:0], mr[22:0]};
    endfunction

    always_comb begin
        w_a_big = {w_ea, w_fa} >= {w_eb, w_fb};
        w_sbig  = w_a_big ? w_sa : w_sb;
        w_ebig  = w_a_big ? w_ea : w_eb;
        w_ediff = w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);
        w_mbig  = w_a_big ? {1'b1, w_fa, 3'b0} : {1'b1, w_fb, 3'b0};
        w_msml  = w_a_big ? {1'b1, w_fb, 3'b0} : {1'b1, w_fa, 3'b0};
        if (w_ediff >= 8'd27)
            w_mal = 27'd1;
        else
            w_mal = (w_msml >> w_ediff) | 27'(|(w_msml & ~(27'h7FF_FFFF << w_ediff)));
        w_madd  = {1'b0, w_mbig} + {1'b0, w_mal};
        w_mdif  = w_mbig - w_mal;
        w_lz    = lzc27(w_mdif);
        w_mnorm = w_mdif << w_lz;
        w_enorm = signed'({2'b00, w_ebig}) - signed'({5'b0, w_lz});
        o_sum   = FP_ZERO;

        if ((fp_exp_all_ones(i_a) && w_fa != '0) || (fp_exp_all_ones(i_b) && w_fb != '0) ||
            (fp_exp_all_ones(i_a) && fp_exp_all_ones(i_b) && w_sa != w_sb))
            o_sum = FP_QNAN;
        else if (fp_exp_all_ones(i_a))
            o_sum = {w_sa, FP_INF[30:0]};
        else if (fp_exp_all_ones(i_b))
            o_sum = {w_sb, FP_INF[30:0]};
        else if (w_ea == '0 && w_eb == '0)
            o_sum = {w_sa & w_sb, 31'b0};
        else if (w_ea == '0)
            o_sum = i_b;
        else if (w_eb == '0)
            o_sum = i_a;
        else if (w_sa == w_sb) begin
            if (w_madd[27])
                o_sum = round_pack(w_sbig, signed'({2'b00, w_ebig}) + 10'sd1,
                                   w_madd[27:1] | 27'(w_madd[0]));
            else
                o_sum = round_pack(w_sbig, signed'({2'b00, w_ebig}), w_madd[26:0]);
        end else if (w_mdif == '0)
            o_sum = FP_ZERO;
        else
            o_sum = round_pack(w_sbig, w_enorm, w_mnorm);
    end

endmodule

// File: rtl/fp_accumulate_mc.sv
// Multi-channel FP32 accumulator: per-channel running totals, shared adder, lowest-index result arbiter.
module fp_accumulate_mc
    import fp_accumulate_mc_pkg::*;
#(
    parameter int N_CHAN = 4,
    parameter int CH_W   = 2,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic rst_n,
    fp_accumulate_mc_if.slave bus
);

    ch_state_e        r_state     [N_CHAN];
    ch_state_e        w_state_nxt [N_CHAN];
    logic [31:0]      r_acc       [N_CHAN];
    logic [31:0]      w_acc_nxt   [N_CHAN];
    logic [CNT_W-1:0] r_cnt       [N_CHAN];
    logic [CNT_W-1:0] w_cnt_nxt   [N_CHAN];
    logic [N_CHAN-1:0] r_ovf, w_ovf_nxt, w_start_ok, w_fin_ok, w_pend;

    logic             w_chan_ok, w_smp_ok, w_err, w_arb_vld, w_sum_ovf;
    logic [CH_W-1:0]  w_chan_idx, w_arb_idx;
    logic [31:0]      w_add_a, w_sum;

    logic [31:0]      r_result_p1;
    logic [CH_W-1:0]  r_chan_p1;
    logic [CNT_W-1:0] r_cnt_p1;
    logic             r_ovf_p1, r_done_p1, r_err_p1;

    // A start on a channel the same cycle as its sample makes the sample the first term.
    assign w_chan_ok  = int'(bus.chan) < N_CHAN;
    assign w_chan_idx = w_chan_ok ? bus.chan : '0;
    assign w_add_a    = w_start_ok[w_chan_idx] ? FP_ZERO : r_acc[w_chan_idx];
    assign w_smp_ok   = bus.valid && w_chan_ok &&
                        (r_state[w_chan_idx] == CH_ACTIVE || w_start_ok[w_chan_idx]);
    assign w_sum_ovf  = fp_exp_all_ones(w_sum);

    fp_accumulate_mc_fp32_add u_add (
        .i_a   (w_add_a),
        .i_b   (bus.data),
        .o_sum (w_sum)
    );

    always_comb begin
        w_err     = bus.valid && !w_smp_ok;
        w_arb_vld = 1'b0;
        w_arb_idx = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            w_start_ok[c] = bus.start[c] && r_state[c] != CH_PENDING;
            w_fin_ok[c]   = bus.finished[c] && !bus.start[c] && r_state[c] == CH_ACTIVE;
            w_pend[c]     = r_state[c] == CH_PENDING;
            bus.busy[c]   = r_state[c] != CH_IDLE;
            if ((bus.start[c] && r_state[c] == CH_PENDING) || (bus.start[c] && bus.finished[c]) ||
                (bus.finished[c] && r_state[c] != CH_ACTIVE))
                w_err = 1'b1;
        end
        for (int c = N_CHAN - 1; c >= 0; c--) begin
            if (w_pend[c]) begin
                w_arb_vld = 1'b1;
                w_arb_idx = CH_W'(c);
            end
        end
    end

    always_comb begin
        for (int c = 0; c < N_CHAN; c++) begin
            w_state_nxt[c] = r_state[c];
            w_acc_nxt[c]   = r_acc[c];
            w_cnt_nxt[c]   = r_cnt[c];
            w_ovf_nxt[c]   = r_ovf[c];
            if (w_start_ok[c]) begin
                w_state_nxt[c] = CH_ACTIVE;
                w_acc_nxt[c]   = FP_ZERO;
                w_cnt_nxt[c]   = '0;
                w_ovf_nxt[c]   = 1'b0;
                if (w_smp_ok && w_chan_idx == CH_W'(c)) begin
                    w_acc_nxt[c] = w_sum;
                    w_cnt_nxt[c] = CNT_W'(1);
                    w_ovf_nxt[c] = w_sum_ovf;
                end
            end else if (r_state[c] == CH_ACTIVE) begin
                if (w_smp_ok && w_chan_idx == CH_W'(c)) begin
                    w_acc_nxt[c] = w_sum;
                    w_cnt_nxt[c] = (r_cnt[c] == '1) ? r_cnt[c] : r_cnt[c] + CNT_W'(1);
                    w_ovf_nxt[c] = r_ovf[c] | w_sum_ovf;
                end
                if (w_fin_ok[c])
                    w_state_nxt[c] = CH_PENDING;
            end else if (r_state[c] == CH_PENDING && w_arb_vld && w_arb_idx == CH_W'(c)) begin
                w_state_nxt[c] = CH_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CHAN; c++) begin
                r_state[c] <= CH_IDLE;
                r_acc[c]   <= FP_ZERO;
                r_cnt[c]   <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int c = 0; c < N_CHAN; c++) begin
                r_state[c] <= w_state_nxt[c];
                r_acc[c]   <= w_acc_nxt[c];
                r_cnt[c]   <= w_cnt_nxt[c];
            end
            r_ovf <= w_ovf_nxt;
        end
    end

    // Output stage: the arbiter's pick is registered onto the shared result port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_p1 <= FP_ZERO;
            r_chan_p1   <= '0;
            r_cnt_p1    <= '0;
            r_ovf_p1    <= 1'b0;
            r_done_p1   <= 1'b0;
            r_err_p1    <= 1'b0;
        end else begin
            r_done_p1 <= w_arb_vld;
            r_err_p1  <= w_err;
            if (w_arb_vld) begin
                r_result_p1 <= r_acc[w_arb_idx];
                r_chan_p1   <= w_arb_idx;
                r_cnt_p1    <= r_cnt[w_arb_idx];
                r_ovf_p1    <= r_ovf[w_arb_idx];
            end
        end
    end

    assign bus.result      = r_result_p1;
    assign bus.result_chan = r_chan_p1;
    assign bus.result_cnt  = r_cnt_p1;
    assign bus.result_ovf  = r_ovf_p1;
    assign bus.done        = r_done_p1;
    assign bus.err         = r_err_p1;

endmodule

// File: tb/tb_fp_accumulate_mc.sv
// Self-checking bench for fp_accumulate_mc: directed scenarios plus randomized channel traffic.
module tb_fp_accumulate_mc;

    localparam int N_CHAN = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 16;
    localparam logic [31:0] ONE = 32'h3F80_0000;
    localparam logic [31:0] TWO = 32'h4000_0000;
    localparam logic [31:0] MAX = 32'h7F7F_FFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    typedef struct packed {
        logic [31:0]      res;
        logic [CH_W-1:0]  ch;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } out_t;

    out_t q[$];

    fp_accumulate_mc_if #(.N_CHAN(N_CHAN), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

    fp_accumulate_mc #(.N_CHAN(N_CHAN), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.done === 1'b1)
            q.push_back({bus.result, bus.result_chan, bus.result_cnt, bus.result_ovf});

    // Exact-sum reference: both operands scaled to a common 2^-149 grid, summed, rounded once.
    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        logic sa, sb, s;
        logic [7:0] ea, eb;
        logic [22:0] fa, fb;
        logic signed [299:0] va, vb, vs;
        logic [299:0] mag, rem, half, sig;
        int p, sh, e;
        {sa, ea, fa} = a;
        {sb, eb, fb} = b;
        if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) return 32'h7FC0_0000;
        if (ea == 8'hFF && eb == 8'hFF) return (sa == sb) ? a : 32'h7FC0_0000;
        if (ea == 8'hFF) return a;
        if (eb == 8'hFF) return b;
        if (ea == 0 && eb == 0) return {sa & sb, 31'b0};
        va = '0;
        vb = '0;
        if (ea != 0) va = 300'({1'b1, fa}) << (ea - 1);
        if (eb != 0) vb = 300'({1'b1, fb}) << (eb - 1);
        if (sa) va = -va;
        if (sb) vb = -vb;
        vs = va + vb;
        if (vs == 0) return 32'h0;
        s   = vs < 0;
        mag = s ? 300'(-vs) : 300'(vs);
        p = -1;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p < 23) return {s, 31'b0};
        sh  = p - 23;
        sig = mag >> sh;
        e   = sh + 1;
        if (sh > 0) begin
            rem  = mag & ((300'd1 << sh) - 300'd1);
            half = 300'd1 << (sh - 1);
            if (rem > half || (rem == half && sig[0])) sig = sig + 300'd1;
        end
        if (sig[24]) begin
            sig = sig >> 1;
            e++;
        end
        if (e >= 255) return {s, 8'hFF, 23'b0};
        return {s, 8'(e), sig[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        return {r[31], 8'(118 + $urandom_range(0, 15)), r[22:0]};
    endfunction

    task automatic drive(input logic [3:0] st, input logic [3:0] fin, input logic v,
                         input logic [1:0] ch, input logic [31:0] d);
        bus.start    = st;
        bus.finished = fin;
        bus.valid    = v;
        bus.chan     = ch;
        bus.data     = d;
        @(posedge clk);
        #1;
        bus.start    = '0;
        bus.finished = '0;
        bus.valid    = 1'b0;
        bus.chan     = '0;
        bus.data     = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        idle(2);
        checks++;
        if ({bus.result, bus.result_chan, bus.result_cnt, bus.result_ovf, bus.done, bus.busy, bus.err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h %h %h %b %b %b %b want all zero", bus.result,
                     bus.result_chan, bus.result_cnt, bus.result_ovf, bus.done, bus.busy, bus.err);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_single();
        drive(4'b0001, 4'b0000, 1'b0, 2'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(4'b0000, 4'b0000, 1'b1, 2'd0, ONE);
            if (i < 3) idle(1);
        end
        drive(4'b0000, 4'b0001, 1'b0, 2'd0, 32'h0);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 4'b0001) begin
            failures++;
            $display("FAIL single_latency_early: got done=%b busy=%b want done=0 busy=0001", bus.done, bus.busy);
        end
        idle(1);
        checks++;
        if ({bus.done, bus.result, bus.result_chan, bus.result_cnt, bus.result_ovf} !== {1'b1, 32'h4080_0000, 2'd0, 16'd4, 1'b0}) begin
            failures++;
            $display("FAIL single_result: got done=%b res=%h ch=%0d cnt=%0d ovf=%b want 1 40800000 0 4 0",
                     bus.done, bus.result, bus.result_chan, bus.result_cnt, bus.result_ovf);
        end
        idle(1);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 4'b0000) begin
            failures++;
            $display("FAIL single_pulse_end: got done=%b busy=%b want 0 0000", bus.done, bus.busy);
        end
    endtask

    task automatic test_interleave();
        drive(4'b0011, 4'b0000, 1'b0, 2'd0, 32'h0);
        drive(4'b0000, 4'b0000, 1'b1, 2'd0, ONE);
        drive(4'b0000, 4'b0000, 1'b1, 2'd1, TWO);
        drive(4'b0000, 4'b0000, 1'b1, 2'd0, ONE);
        drive(4'b0000, 4'b0000, 1'b1, 2'd1, TWO);
        drive(4'b0000, 4'b0000, 1'b1, 2'd0, ONE);
        checks++;
        if (bus.busy !== 4'b0011) begin
            failures++;
            $display("FAIL interleave_busy: got %b want 0011", bus.busy);
        end
        drive(4'b0000, 4'b0011, 1'b0, 2'd0, 32'h0);
        idle(1);
        checks++;
        if ({bus.done, bus.result, bus.result_chan, bus.result_cnt} !== {1'b1, 32'h4040_0000, 2'd0, 16'd3}) begin
            failures++;
            $display("FAIL interleave_ch0: got done=%b res=%h ch=%0d cnt=%0d want 1 40400000 0 3",
                     bus.done, bus.result, bus.result_chan, bus.result_cnt);
        end
        idle(1);
        checks++;
        if ({bus.done, bus.result, bus.result_chan, bus.result_cnt} !== {1'b1, 32'h4080_0000, 2'd1, 16'd2}) begin
            failures++;
            $display("FAIL interleave_ch1: got done=%b res=%h ch=%0d cnt=%0d want 1 40800000 1 2",
                     bus.done, bus.result, bus.result_chan, bus.result_cnt);
        end
        idle(1);
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL interleave_end: got done=%b want 0", bus.done);
        end
    endtask

    task automatic test_same_cycle();
        drive(4'b0100, 4'b0000, 1'b1, 2'd2, ONE);
        drive(4'b0000, 4'b0100, 1'b1, 2'd2, ONE);
        idle(1);
        checks++;
        if ({bus.done, bus.result, bus.result_chan, bus.result_cnt, bus.result_ovf} !== {1'b1, 32'h4000_0000, 2'd2, 16'd2, 1'b0}) begin
            failures++;
            $display("FAIL same_cycle: got done=%b res=%h ch=%0d cnt=%0d ovf=%b want 1 40000000 2 2 0",
                     bus.done, bus.result, bus.result_chan, bus.result_cnt, bus.result_ovf);
        end
        idle(1);
    endtask

    task automatic test_overflow();
        drive(4'b1000, 4'b0000, 1'b0, 2'd0, 32'h0);
        drive(4'b0000, 4'b0000, 1'b1, 2'd3, MAX);
        drive(4'b0000, 4'b0000, 1'b1, 2'd3, MAX);
        drive(4'b0000, 4'b1000, 1'b0, 2'd0, 32'h0);
        idle(1);
        checks++;
        if ({bus.done, bus.result, bus.result_chan, bus.result_cnt, bus.result_ovf} !== {1'b1, 32'h7F80_0000, 2'd3, 16'd2, 1'b1}) begin
            failures++;
            $display("FAIL overflow: got done=%b res=%h ch=%0d cnt=%0d ovf=%b want 1 7f800000 3 2 1",
                     bus.done, bus.result, bus.result_chan, bus.result_cnt, bus.result_ovf);
        end
        idle(1);
    endtask

    task automatic test_protocol_err();
        idle(2);
        drive(4'b0000, 4'b0000, 1'b1, 2'd1, ONE);
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 4'b0000) begin
            failures++;
            $display("FAIL err_valid_idle: got err=%b busy=%b want 1 0000", bus.err, bus.busy);
        end
        drive(4'b0000, 4'b0001, 1'b0, 2'd0, 32'h0);
        checks++;
        if (bus.err !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL err_finish_idle: got err=%b done=%b want 1 0", bus.err, bus.done);
        end
        idle(1);
        checks++;
        if ({bus.err, bus.done, bus.busy} !== 6'b0) begin
            failures++;
            $display("FAIL err_quiet: got err=%b done=%b busy=%b want 0 0 0000", bus.err, bus.done, bus.busy);
        end
        drive(4'b0001, 4'b0001, 1'b0, 2'd0, 32'h0);
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 4'b0001) begin
            failures++;
            $display("FAIL err_start_finish: got err=%b busy=%b want 1 0001", bus.err, bus.busy);
        end
        drive(4'b0010, 4'b0000, 1'b0, 2'd0, 32'h0);
        checks++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL err_clean_start: got err=%b want 0", bus.err);
        end
        drive(4'b0000, 4'b0011, 1'b0, 2'd0, 32'h0);
        drive(4'b0010, 4'b0000, 1'b0, 2'd0, 32'h0);
        checks++;
        if ({bus.err, bus.done, bus.result, bus.result_chan, bus.result_cnt} !== {1'b1, 1'b1, 32'h0, 2'd0, 16'd0}) begin
            failures++;
            $display("FAIL err_start_pending: got err=%b done=%b res=%h ch=%0d cnt=%0d want 1 1 0 0 0",
                     bus.err, bus.done, bus.result, bus.result_chan, bus.result_cnt);
        end
        idle(1);
        checks++;
        if ({bus.done, bus.result_chan, bus.result_cnt, bus.busy} !== {1'b1, 2'd1, 16'd0, 4'b0000}) begin
            failures++;
            $display("FAIL err_pending_kept: got done=%b ch=%0d cnt=%0d busy=%b want 1 1 0 0000",
                     bus.done, bus.result_chan, bus.result_cnt, bus.busy);
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        drive(4'b0001, 4'b0000, 1'b0, 2'd0, 32'h0);
        drive(4'b0000, 4'b0000, 1'b1, 2'd0, ONE);
        drive(4'b0000, 4'b0000, 1'b1, 2'd0, ONE);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.result, bus.result_chan, bus.result_cnt, bus.result_ovf, bus.done, bus.busy, bus.err} !== '0) begin
            failures++;
            $display("FAIL reset_mid: got res=%h ch=%0d cnt=%0d ovf=%b done=%b busy=%b err=%b want all zero",
                     bus.result, bus.result_chan, bus.result_cnt, bus.result_ovf, bus.done, bus.busy, bus.err);
        end
        idle(1);
        rst_n = 1'b1;
        idle(1);
        drive(4'b0001, 4'b0000, 1'b1, 2'd0, ONE);
        drive(4'b0000, 4'b0001, 1'b0, 2'd0, 32'h0);
        idle(1);
        checks++;
        if ({bus.done, bus.result, bus.result_chan, bus.result_cnt, bus.result_ovf} !== {1'b1, ONE, 2'd0, 16'd1, 1'b0}) begin
            failures++;
            $display("FAIL reset_recover: got done=%b res=%h ch=%0d cnt=%0d ovf=%b want 1 3f800000 0 1 0",
                     bus.done, bus.result, bus.result_chan, bus.result_cnt, bus.result_ovf);
        end
        idle(2);
    endtask

    task automatic test_random();
        logic [31:0] acc [N_CHAN];
        int          cnt [N_CHAN];
        logic        ovf [N_CHAN];
        logic [31:0] d;
        logic [1:0]  ch;
        logic        v;
        out_t        got, want;
        int          wait_cyc;
        for (int round = 0; round < 4; round++) begin
            q.delete();
            for (int c = 0; c < N_CHAN; c++) begin
                acc[c] = 32'h0;
                cnt[c] = 0;
                ovf[c] = 1'b0;
            end
            drive(4'b1111, 4'b0000, 1'b0, 2'd0, 32'h0);
            for (int i = 0; i < 40; i++) begin
                v  = ($urandom % 4) != 0;
                ch = 2'($urandom % 4);
                d  = (($urandom % 10) == 0) ? (acc[ch] ^ 32'h8000_0000) : rand_fp();
                if (v) begin
                    acc[ch] = model_add(acc[ch], d);
                    cnt[ch]++;
                    ovf[ch] = ovf[ch] | (acc[ch][30:23] == 8'hFF);
                end
                drive(4'b0000, 4'b0000, v, ch, d);
            end
            drive(4'b0000, 4'b1111, 1'b0, 2'd0, 32'h0);
            wait_cyc = 0;
            while (q.size() < N_CHAN && wait_cyc < 12) begin
                idle(1);
                wait_cyc++;
            end
            checks++;
            if (q.size() != N_CHAN) begin
                failures++;
                $display("FAIL random_done_count round %0d: got %0d results want %0d", round, q.size(), N_CHAN);
            end
            for (int c = 0; c < N_CHAN; c++) begin
                if (q.size() > 0) begin
                    got  = q.pop_front();
                    want = {acc[c], 2'(c), 16'(cnt[c]), ovf[c]};
                    checks++;
                    if (got !== want) begin
                        failures++;
                        $display("FAIL random_result round %0d ch %0d: got res=%h ch=%0d cnt=%0d ovf=%b want res=%h ch=%0d cnt=%0d ovf=%b",
                                 round, c, got.res, got.ch, got.cnt, got.ovf, want.res, want.ch, want.cnt, want.ovf);
                    end
                end
            end
            idle(2);
        end
    endtask

    initial begin
        bus.start    = '0;
        bus.finished = '0;
        bus.valid    = 1'b0;
        bus.chan     = '0;
        bus.data     = '0;
        test_reset();
        test_single();
        test_interleave();
        test_same_cycle();
        test_protocol_err();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
